// File: rtl/laser_pkg.sv
// rtl/laser_pkg.sv - shared sequence codes, lengths and types for the laser packet responder
package laser_pkg;

  localparam logic [7:0] SEQ_START  = 8'hCC;
  localparam logic [7:0] SEQ_STOP   = 8'h55;
  localparam logic [7:0] CODE_ACK   = 8'h11;
  localparam logic [7:0] CODE_FAIL  = 8'hBB;
  localparam logic [7:0] CODE_DONE  = 8'hAA;

  localparam logic [9:0] START_LEN  = 10'd512;
  localparam logic [9:0] STOP_LEN   = 10'd6;
  localparam logic [2:0] ACK_PAIRS  = 3'd4;
  localparam logic [2:0] FAIL_PAIRS = 3'd4;
  localparam logic [2:0] DONE_PAIRS = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_REPLY = 2'd2
  } state_e;

  typedef enum logic {
    KIND_START = 1'b0,
    KIND_STOP  = 1'b1
  } kind_e;

  function automatic logic [9:0] pkt_len(input kind_e kind);
    return (kind == KIND_STOP) ? STOP_LEN : START_LEN;
  endfunction

  function automatic logic [2:0] reply_len(input logic [7:0] code);
    logic [2:0] len;
    case (code)
      CODE_DONE: len = DONE_PAIRS;
      CODE_FAIL: len = FAIL_PAIRS;
      default:   len = ACK_PAIRS;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/laser_idle_timer.sv
// rtl/laser_idle_timer.sv - counts idle clocks while enabled; expired fires on the limit-th idle clock
module laser_idle_timer #(
  parameter logic [15:0] limit = 16'd1024
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic kick,
  output logic expired
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!en || kick) begin
      count_d = '0;
    end else if (count_q != limit) begin
      count_d = count_q + 16'd1;
    end
  end

  // a kick on the limit clock suppresses expiry
  assign expired = en && !kick && (count_q == limit - 16'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/laser_pkt_responder.sv
// rtl/laser_pkt_responder.sv - receives START/STOP laser packets and answers with ACK/DONE/FAIL pairs
// LASER_RESP_CHECKSUM_EN: beat 512 of START is an XOR checksum of beats 2..511
module laser_pkt_responder
  import laser_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = 16'd1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data1,
  input  logic [7:0]  rx_data2,
  input  logic        tx_done,
  output logic        tx_en,
  output logic        tx_ready,
  output logic [7:0]  tx_data1,
  output logic [7:0]  tx_data2,
  output logic        pld_valid,
  output logic [15:0] pld_data,
  output logic        pkt_ok,
  output logic        pkt_abort,
  output logic        link_done
);

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [9:0]  beat_ct_q, beat_ct_d;
  logic [2:0]  reply_ct_q, reply_ct_d;
  logic [7:0]  code_q, code_d;
  logic [15:0] csum_q, csum_d;
  logic        pld_valid_q, pld_valid_d;
  logic [15:0] pld_data_q, pld_data_d;
  logic        pkt_ok_q, pkt_ok_d;
  logic        pkt_abort_q, pkt_abort_d;
  logic        link_done_q, link_done_d;

  logic        expired;
  logic        csum_beat;
  logic [15:0] rx_word;
  logic [9:0]  beat_next;
  logic [2:0]  reply_next;

  assign rx_word    = {rx_data1, rx_data2};
  assign beat_next  = beat_ct_q + 10'd1;
  assign reply_next = reply_ct_q + 3'd1;

`ifdef LASER_RESP_CHECKSUM_EN
  assign csum_beat = (kind_q == KIND_START) && (beat_next == START_LEN);
`else
  assign csum_beat = 1'b0;
`endif

  laser_idle_timer #(.limit(TIMEOUT_CYC)) u_idle_timer (
    .clock   (clock),
    .reset   (reset),
    .en      (state_q == ST_RECV),
    .kick    (rx_valid),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    beat_ct_d   = beat_ct_q;
    reply_ct_d  = reply_ct_q;
    code_d      = code_q;
    csum_d      = csum_q;
    pld_valid_d = 1'b0;
    pld_data_d  = pld_data_q;
    pkt_ok_d    = 1'b0;
    pkt_abort_d = 1'b0;
    link_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        beat_ct_d  = '0;
        reply_ct_d = '0;
        if (rx_valid && rx_data1 == SEQ_START && rx_data2 == SEQ_START) begin
          state_d   = ST_RECV;
          kind_d    = KIND_START;
          beat_ct_d = 10'd1;
          csum_d    = '0;
        end else if (rx_valid && rx_data1 == SEQ_STOP && rx_data2 == SEQ_STOP) begin
          state_d   = ST_RECV;
          kind_d    = KIND_STOP;
          beat_ct_d = 10'd1;
          csum_d    = '0;
        end
      end

      ST_RECV: begin
        if (rx_valid) begin
          beat_ct_d = beat_next;
          if (!csum_beat) begin
            pld_valid_d = 1'b1;
            pld_data_d  = rx_word;
            if (beat_next < START_LEN) csum_d = csum_q ^ rx_word;
          end
          if (beat_next == pkt_len(kind_q)) begin
            state_d    = ST_REPLY;
            reply_ct_d = '0;
            if (kind_q == KIND_STOP) begin
              code_d      = CODE_DONE;
              link_done_d = 1'b1;
            end else if (csum_beat && rx_word != csum_q) begin
              code_d      = CODE_FAIL;
              pkt_abort_d = 1'b1;
            end else begin
              code_d   = CODE_ACK;
              pkt_ok_d = 1'b1;
            end
          end
        end else if (expired) begin
          state_d     = ST_REPLY;
          reply_ct_d  = '0;
          code_d      = CODE_FAIL;
          pkt_abort_d = 1'b1;
        end
      end

      ST_REPLY: begin
        // receive path is deaf here: the link is half-duplex
        if (tx_done) begin
          if (reply_next == reply_len(code_q)) begin
            state_d    = ST_IDLE;
            reply_ct_d = '0;
            beat_ct_d  = '0;
          end else begin
            reply_ct_d = reply_next;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      kind_q      <= KIND_START;
      beat_ct_q   <= '0;
      reply_ct_q  <= '0;
      code_q      <= '0;
      csum_q      <= '0;
      pld_valid_q <= 1'b0;
      pld_data_q  <= '0;
      pkt_ok_q    <= 1'b0;
      pkt_abort_q <= 1'b0;
      link_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      beat_ct_q   <= beat_ct_d;
      reply_ct_q  <= reply_ct_d;
      code_q      <= code_d;
      csum_q      <= csum_d;
      pld_valid_q <= pld_valid_d;
      pld_data_q  <= pld_data_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_abort_q <= pkt_abort_d;
      link_done_q <= link_done_d;
    end
  end

  assign tx_en     = (state_q == ST_REPLY);
  assign tx_ready  = (state_q == ST_REPLY);
  assign tx_data1  = (state_q == ST_REPLY) ? code_q : 8'h00;
  assign tx_data2  = (state_q == ST_REPLY) ? code_q : 8'h00;
  assign pld_valid = pld_valid_q;
  assign pld_data  = pld_data_q;
  assign pkt_ok    = pkt_ok_q;
  assign pkt_abort = pkt_abort_q;
  assign link_done = link_done_q;

endmodule

// File: tb/tb_laser_pkt_responder.sv
// tb/tb_laser_pkt_responder.sv - randomized bench for laser_pkt_responder against a packet-level model
module tb_laser_pkt_responder;

  localparam int TO = 1024;
`ifdef LASER_RESP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data1, rx_data2;
  logic        tx_done;
  logic        tx_en, tx_ready;
  logic [7:0]  tx_data1, tx_data2;
  logic        pld_valid;
  logic [15:0] pld_data;
  logic        pkt_ok, pkt_abort, link_done;

  laser_pkt_responder dut (
    .clock     (clock),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data1  (rx_data1),
    .rx_data2  (rx_data2),
    .tx_done   (tx_done),
    .tx_en     (tx_en),
    .tx_ready  (tx_ready),
    .tx_data1  (tx_data1),
    .tx_data2  (tx_data2),
    .pld_valid (pld_valid),
    .pld_data  (pld_data),
    .pkt_ok    (pkt_ok),
    .pkt_abort (pkt_abort),
    .link_done (link_done)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // packet-level reference: phase 0 idle, 1 receiving, 2 replying
  int          m_phase, m_len, m_cnt, m_idle, m_rep, m_pairs;
  bit          m_stop;
  logic [15:0] m_csum;
  logic [7:0]  m_code;
  bit          e_pld, e_ok, e_abort, e_done;
  logic [15:0] e_pld_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_len = 0; m_cnt = 0; m_idle = 0; m_rep = 0; m_pairs = 0;
    m_stop = 1'b0; m_csum = '0; m_code = '0;
    e_pld = 1'b0; e_ok = 1'b0; e_abort = 1'b0; e_done = 1'b0; e_pld_data = '0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d1, input logic [7:0] d2, input bit done);
    logic [15:0] w;
    bit          cbeat;
    w = {d1, d2};
    case (m_phase)
      0: if (v) begin
        if (d1 == 8'hCC && d2 == 8'hCC) begin
          m_phase = 1; m_len = 512; m_stop = 1'b0; m_cnt = 1; m_idle = 0; m_csum = '0;
        end else if (d1 == 8'h55 && d2 == 8'h55) begin
          m_phase = 1; m_len = 6; m_stop = 1'b1; m_cnt = 1; m_idle = 0; m_csum = '0;
        end
      end
      1: if (v) begin
        m_cnt++;
        m_idle = 0;
        cbeat = CSUM && !m_stop && m_cnt == 512;
        if (!cbeat) begin
          e_pld = 1'b1;
          e_pld_data = w;
          if (m_cnt <= 511) m_csum ^= w;
        end
        if (m_cnt == m_len) begin
          m_phase = 2; m_rep = 0;
          if (m_stop) begin
            m_code = 8'hAA; m_pairs = 2; e_done = 1'b1;
          end else if (cbeat && w != m_csum) begin
            m_code = 8'hBB; m_pairs = 4; e_abort = 1'b1;
          end else begin
            m_code = 8'h11; m_pairs = 4; e_ok = 1'b1;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_phase = 2; m_rep = 0; m_code = 8'hBB; m_pairs = 4; e_abort = 1'b1;
        end
      end
      default: if (done) begin
        m_rep++;
        if (m_rep == m_pairs) m_phase = 0;
      end
    endcase
  endtask

  task automatic cycle(input bit v, input logic [7:0] d1, input logic [7:0] d2, input bit done);
    rx_valid = v; rx_data1 = d1; rx_data2 = d2; tx_done = done;
    model_step(v, d1, d2, done);
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
    tx_done  = 1'b0;
    chk("pld_valid", 32'(pld_valid), 32'(e_pld));
    if (e_pld) chk("pld_data", 32'(pld_data), 32'(e_pld_data));
    chk("pkt_ok", 32'(pkt_ok), 32'(e_ok));
    chk("pkt_abort", 32'(pkt_abort), 32'(e_abort));
    chk("link_done", 32'(link_done), 32'(e_done));
    chk("tx_en", 32'(tx_en), 32'(m_phase == 2));
    chk("tx_ready", 32'(tx_ready), 32'(m_phase == 2));
    chk("tx_data1", 32'(tx_data1), 32'(m_phase == 2 ? m_code : 8'h00));
    chk("tx_data2", 32'(tx_data2), 32'(m_phase == 2 ? m_code : 8'h00));
    e_pld = 1'b0; e_ok = 1'b0; e_abort = 1'b0; e_done = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tx_en"}, 32'(tx_en), 32'd0);
    chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd0);
    chk({tag, "_tx_data1"}, 32'(tx_data1), 32'd0);
    chk({tag, "_tx_data2"}, 32'(tx_data2), 32'd0);
    chk({tag, "_pld_valid"}, 32'(pld_valid), 32'd0);
    chk({tag, "_pld_data"}, 32'(pld_data), 32'd0);
    chk({tag, "_pkt_ok"}, 32'(pkt_ok), 32'd0);
    chk({tag, "_pkt_abort"}, 32'(pkt_abort), 32'd0);
    chk({tag, "_link_done"}, 32'(link_done), 32'd0);
  endtask

  // asserted mid-cycle so the zeroed outputs prove the reset is asynchronous
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check_zero("rst_async");
    @(posedge clock);
    #1 check_zero("rst_held");
    reset = 1'b0;
    tx_done = 1'b0;
    rx_valid = 1'b0;
    model_reset();
  endtask

  // csum_mode: 0 plain last beat, 1 correct checksum on beat 512, 2 corrupted checksum
  task automatic send_packet(input bit is_stop, input int npay, input int gap_lo, input int gap_hi,
                             input bit fixed, input int csum_mode);
    logic [15:0] x, w;
    logic [7:0]  hdr;
    x = '0;
    hdr = is_stop ? 8'h55 : 8'hCC;
    cycle(1'b1, hdr, hdr, 1'b0);
    for (int i = 0; i < npay; i++) begin
      idle(int'($urandom_range(gap_hi, gap_lo)));
      w = fixed ? 16'h0102 : 16'($urandom);
      if (csum_mode != 0 && i == 510) w = (csum_mode == 1) ? x : (x ^ 16'h8001);
      if (i < 510) x ^= w;
      cycle(1'b1, w[15:8], w[7:0], 1'b0);
    end
  endtask

  task automatic serve_reply(input int rst_at);
    int g;
    for (int p = 0; p < 4 && m_phase == 2; p++) begin
      g = int'($urandom_range(3, 0));
      for (int k = 0; k < g; k++)
        cycle(1'($urandom_range(1, 0)), 8'($urandom), 8'($urandom), 1'b0);
      if (p == rst_at) begin
        do_reset();
        return;
      end
      cycle(1'b0, 8'h00, 8'h00, 1'b1);
    end
    idle(2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] a, b;
    reset = 1'b1; rx_valid = 1'b0; tx_done = 1'b0; rx_data1 = '0; rx_data2 = '0;
    model_reset();
    @(posedge clock);
    #1 check_zero("por");
    reset = 1'b0;
    idle(2);

    cycle(1'b1, 8'hCC, 8'h55, 1'b0);
    cycle(1'b1, 8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      idle(int'($urandom_range(2, 0)));
      cycle(1'b1, a, b, 1'b0);
    end
    idle(3);

    send_packet(1'b0, 511, 79, 79, 1'b1, 0);
    serve_reply(-1);

    send_packet(1'b1, 5, 0, 3, 1'b0, 0);
    serve_reply(-1);

    send_packet(1'b0, 10, 0, 3, 1'b0, 0);
    idle(TO + 2);
    serve_reply(-1);

    send_packet(1'b0, 511, 0, 3, 1'b0, 1);
    serve_reply(-1);
    send_packet(1'b0, 511, 0, 3, 1'b0, 2);
    serve_reply(-1);

    for (int i = 0; i < 3; i++) begin
      send_packet(1'b1, 5, 0, 5, 1'b0, 0);
      serve_reply(-1);
    end

    send_packet(1'b0, 511, 0, 1, 1'b0, 0);
    serve_reply(1);
    cycle(1'b1, 8'h12, 8'h34, 1'b0);
    idle(2);

    send_packet(1'b0, 3, 0, 2, 1'b0, 0);
    idle(TO - 1);
    cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    idle(4);
    do_reset();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/laser_pkt_responder.md
LASER_PKT_RESPONDER -- requirements
Module: laser_pkt_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16'd1024, the idle clocks allowed between beats of a packet before FAIL.
REQ-002 SHALL have ports: clock in 1, system clock; reset in 1, asynchronous, active-high.
REQ-003 rx_valid in 1, one-cycle pulse: a byte pair was received on both lasers.
REQ-004 rx_data1, rx_data2 in 8 each, the received bytes; valid only when rx_valid is high.
REQ-005 tx_done in 1, one-cycle pulse: the transmitter finished one byte pair.
REQ-006 tx_en out 1, enables the laser transmitter.
REQ-007 tx_ready out 1, data-ready to the transmitter.
REQ-008 tx_data1, tx_data2 out 8 each, reply bytes.
REQ-009 pld_valid out 1, payload beat strobe.
REQ-010 pld_data out 16, payload beat, {rx_data1, rx_data2}.
REQ-011 pkt_ok out 1, one-cycle pulse: packet accepted.
REQ-012 pkt_abort out 1, one-cycle pulse: downstream discards the current packet.
REQ-013 link_done out 1, one-cycle pulse: STOP packet accepted.

Function
REQ-014 A beat SHALL be one rx_valid pulse. Packet length includes the header beat: START is 512 beats, STOP is 6 beats.
REQ-015 State IDLE: on rx_valid with both bytes 8'hCC, go to RECV, kind=START, beat_ct=1. On both bytes 8'h55, go to RECV, kind=STOP, beat_ct=1.
REQ-016 In IDLE, any other beat SHALL be dropped silently, and the FSM stays in IDLE.
REQ-017 State RECV: each rx_valid SHALL increment beat_ct (10 bits) and clear the idle timer.
REQ-018 In RECV, each non-header beat SHALL produce pld_valid with pld_data exactly one clock after its rx_valid.
REQ-019 In RECV, when beat_ct reaches the packet length, the FSM SHALL enter REPLY on the next clock. Code is 8'h11 (ACK, 4 pairs) for START, or 8'hAA (DONE, 2 pairs) for STOP.
REQ-020 pkt_ok SHALL pulse on REPLY entry for ACK. link_done SHALL pulse on REPLY entry for DONE.
REQ-021 In RECV, the idle timer SHALL count clocks without rx_valid. At TIMEOUT_CYC the FSM enters REPLY with code 8'hBB (FAIL, 4 pairs) and pulses pkt_abort.
REQ-022 If rx_valid coincides with the timer reaching TIMEOUT_CYC, rx_valid SHALL win and no timeout occurs.
REQ-023 State REPLY: tx_en=1, tx_ready=1, tx_data1=tx_data2=code. Each tx_done increments reply_ct.
REQ-024 When reply_ct reaches the reply length, the FSM SHALL go to IDLE on the next clock with tx_en=0 and tx_ready=0.
REQ-025 rx_valid during REPLY SHALL be ignored; the link is half-duplex.
REQ-026 No beat counter SHALL wrap: beat_ct never exceeds 512, and reply_ct never exceeds 4.
REQ-027 Outside REPLY, tx_data1 and tx_data2 SHALL be 8'h00.

Reset
REQ-028 Reset SHALL force IDLE immediately, including mid-packet or mid-reply; no abort pulse is issued.
REQ-029 During reset all outputs SHALL be 0, and beat_ct, reply_ct and the timer SHALL be 0.

Configuration
REQ-030 LASER_RESP_CHECKSUM_EN defined: beat 512 of a START packet SHALL be a 16-bit XOR of payload beats 2..511 and is not forwarded on pld_valid.
REQ-031 With LASER_RESP_CHECKSUM_EN defined, a checksum match SHALL give ACK with pkt_ok. A mismatch SHALL give FAIL with pkt_abort.
REQ-032 LASER_RESP_CHECKSUM_EN undefined: beat 512 SHALL be forwarded as payload, and a full count always gives ACK. STOP packets are never checksummed.

Structure
REQ-033 Shared package laser_pkg SHALL hold: sequence codes (CC, 55, 11, BB, AA), packet and reply lengths (512, 6, 4, 4, 2), and the enum types for state and packet kind.
REQ-034 The idle timer SHALL be one sub-module, laser_idle_timer: parameter limit; inputs en and kick; output expired.

Verification
REQ-035 START header, then 511 beats of 16'h0102, one every 80 clocks -> 511 pld_valid pulses, pkt_ok once, then 4 tx_done handshakes with tx_data=8'h11, then IDLE.
REQ-036 STOP header plus 5 beats -> link_done pulse, 2 pairs of 8'hAA sent, tx_en drops one clock after the second tx_done.
REQ-037 START header, 10 beats, then silence for 1024 clocks -> pkt_abort pulse, 4 pairs of 8'hBB.
REQ-038 Beat pairs (CC,55) and (12,34) while in IDLE -> no output activity.
REQ-039 With LASER_RESP_CHECKSUM_EN defined: bad checksum on beat 512 -> FAIL, 510 payload beats forwarded. Good checksum -> ACK.
REQ-040 Reset asserted during the 2nd ACK pair, and separately at the exact timeout clock with a coincident rx_valid -> IDLE with all outputs 0 on reset; the coincident beat is counted with no FAIL.
